// File: rtl/sd_cmd_master.sv
// rtl/sd_cmd_master.sv - SPI-mode SD command issuer: CRC7 framed command out, R1 poll in
module sd_cmd_master #(
    parameter int CLK_DIV  = 4,
    parameter int MAX_POLL = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic        resp_valid,
    output logic [7:0]  resp_r1,
    output logic        resp_timeout,
    output logic        busy,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        cs_n
);

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] POLL_LAST = 16'(MAX_POLL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_POLL,
        S_DONE,
        S_RESP
    } state_t;

    state_t      state;
    logic [15:0] div_cnt;
    logic [5:0]  bit_cnt;
    logic [15:0] poll_cnt;
    logic [46:0] frame;
    logic [7:0]  poll_byte;
    logic [7:0]  result;
    logic        result_to;
    logic [39:0] msg;
    logic        tick;

    function automatic logic [6:0] crc7(input logic [39:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb  = data[i] ^ crc[6];
            crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return crc;
    endfunction

    assign msg  = {2'b01, cmd_index, cmd_arg};
    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            sclk         <= 1'b0;
            cs_n         <= 1'b1;
            mosi         <= 1'b1;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            resp_valid   <= 1'b0;
            resp_timeout <= 1'b0;
            resp_r1      <= 8'hFF;
            div_cnt      <= 16'd0;
            bit_cnt      <= 6'd0;
            poll_cnt     <= 16'd0;
            frame        <= 47'd0;
            poll_byte    <= 8'hFF;
            result       <= 8'hFF;
            result_to    <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        // mosi carries frame bit 47; frame holds the remaining 47 bits
                        mosi      <= msg[39];
                        frame     <= {msg[38:0], crc7(msg), 1'b1};
                        cs_n      <= 1'b0;
                        sclk      <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        div_cnt   <= 16'd0;
                        bit_cnt   <= 6'd0;
                        state     <= S_SEND;
                    end
                end
                S_SEND, S_POLL: begin
                    if (!tick) begin
                        div_cnt <= div_cnt + 16'd1;
                    end else begin
                        div_cnt <= 16'd0;
                        sclk    <= ~sclk;
                        if (!sclk) begin
                            if (state == S_POLL)
                                poll_byte <= {poll_byte[6:0], miso};
                        end else if (state == S_SEND) begin
                            frame <= {frame[45:0], 1'b1};
                            if (bit_cnt == 6'd47) begin
                                mosi     <= 1'b1;
                                bit_cnt  <= 6'd0;
                                poll_cnt <= 16'd0;
                                state    <= S_POLL;
                            end else begin
                                mosi    <= frame[46];
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end else if (bit_cnt == 6'd7) begin
                            // falling edge closing a poll byte: decide response or retry
                            bit_cnt  <= 6'd0;
                            poll_cnt <= poll_cnt + 16'd1;
                            if (!poll_byte[7]) begin
                                result    <= poll_byte;
                                result_to <= 1'b0;
                                state     <= S_DONE;
                            end else if (poll_cnt == POLL_LAST) begin
                                result    <= 8'hFF;
                                result_to <= 1'b1;
                                state     <= S_DONE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end
                S_DONE: begin
                    cs_n         <= 1'b1;
                    resp_valid   <= 1'b1;
                    resp_r1      <= result;
                    resp_timeout <= result_to;
                    state        <= S_RESP;
                end
                S_RESP: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_master.sv
// tb/tb_sd_cmd_master.sv - self-checking bench for sd_cmd_master with a scripted SD card model
module tb_sd_cmd_master;

    localparam int D  = 4;
    localparam int MP = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_index = 6'd0;
    logic [31:0] cmd_arg = 32'd0;
    logic        resp_valid;
    logic [7:0]  resp_r1;
    logic        resp_timeout;
    logic        busy;
    logic        sclk;
    logic        mosi;
    logic        miso = 1'b1;
    logic        cs_n;

    sd_cmd_master #(.CLK_DIV(D), .MAX_POLL(MP)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg), .resp_valid(resp_valid),
        .resp_r1(resp_r1), .resp_timeout(resp_timeout), .busy(busy),
        .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;
    logic [7:0]  card_bytes [0:15];
    int          card_n = 0;
    int          rise_cnt = 0;
    logic [47:0] cap = 48'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic bound_fail(input string name);
        checks++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // CRC as remainder of polynomial division of msg*x^7 by x^7+x^3+1
    function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        logic [46:0] r;
        m = {2'b01, idx, arg};
        r = {m, 7'd0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return {m, r[6:0], 1'b1};
    endfunction

    task automatic set_card(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        card_n = n;
        card_bytes[0] = b0;
        card_bytes[1] = b1;
        card_bytes[2] = b2;
    endtask

    initial forever @(posedge clk) cyc++;

    initial forever begin
        @(negedge cs_n);
        rise_cnt = 0;
        cap = 48'd0;
    end

    initial forever begin
        @(posedge sclk);
        if (rise_cnt < 48) cap = {cap[46:0], mosi};
        rise_cnt++;
    end

    // Card: after the 48 command bits, present scripted poll bytes, then 0xFF
    initial begin
        int fc;
        int j;
        int b;
        logic [7:0] by;
        fc = 0;
        forever begin
            @(negedge sclk or posedge cs_n);
            if (cs_n) begin
                fc = 0;
                miso = 1'b1;
            end else begin
                fc++;
                if (fc >= 48) begin
                    j = (fc - 48) / 8;
                    b = (fc - 48) % 8;
                    by = (j < card_n) ? card_bytes[j] : 8'hFF;
                    miso = by[7 - b];
                end
            end
        end
    end

    // Reference model and per-cycle output comparison
    initial begin
        logic        m_active;
        int          m_t0;
        int          m_L;
        int          m_k;
        int          c;
        logic [47:0] m_frame;
        logic [7:0]  m_r1;
        logic        m_to;
        logic [7:0]  held_r1;
        logic        held_to;
        logic [7:0]  by;
        logic        se;
        logic        me;
        logic [13:0] e;
        logic [13:0] a;
        m_active = 1'b0; m_t0 = 0; m_L = 0; m_k = 0;
        m_frame = 48'd0; m_r1 = 8'hFF; m_to = 1'b0;
        held_r1 = 8'hFF; held_to = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_active = 1'b0;
                held_r1 = 8'hFF;
                held_to = 1'b0;
            end
            c = cyc - m_t0;
            if (m_active && c >= m_L + 2) begin
                held_r1 = m_r1;
                held_to = m_to;
                m_active = 1'b0;
            end
            if (!m_active) begin
                e = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, held_to, held_r1};
            end else if (c == m_L + 1) begin
                e = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, m_to, m_r1};
                chk("rise_count", 64'(rise_cnt), 64'(48 + 8 * m_k));
                chk("mosi_frame", cap, m_frame);
            end else begin
                se = ((c / D) % 2) == 1;
                me = (c < 96 * D) ? m_frame[47 - c / (2 * D)] : 1'b1;
                e = {1'b0, se, me, 1'b0, 1'b1, 1'b0, held_to, held_r1};
            end
            a = {cs_n, sclk, mosi, cmd_ready, busy, resp_valid, resp_timeout, resp_r1};
            chk("outputs", a, e);
            if (rst_n && cmd_valid && !m_active) begin
                m_active = 1'b1;
                m_t0 = cyc + 1;
                m_frame = model_frame(cmd_index, cmd_arg);
                m_k = MP; m_r1 = 8'hFF; m_to = 1'b1;
                for (int j = 0; j < MP; j++) begin
                    by = (j < card_n) ? card_bytes[j] : 8'hFF;
                    if (!by[7]) begin
                        m_k = j + 1; m_r1 = by; m_to = 1'b0;
                        break;
                    end
                end
                m_L = 96 * D + 16 * D * m_k;
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!cmd_ready && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) bound_fail("ready_wait");
    endtask

    task automatic wait_resp(input int t_acc, output int lat);
        int n;
        n = 0;
        while (!resp_valid && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!resp_valid) bound_fail("resp_wait");
        lat = cyc - t_acc;
    endtask

    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, output int lat);
        int t_acc;
        wait_ready();
        cmd_index = idx;
        cmd_arg = arg;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        t_acc = cyc;
        cmd_valid = 1'b0;
        wait_resp(t_acc, lat);
    endtask

    initial begin
        int lat;
        int t_acc;
        int n;
        for (int i = 0; i < 16; i++) card_bytes[i] = 8'hFF;

        chk("model_cmd0", model_frame(6'd0, 32'd0), 48'h400000000095);
        chk("model_cmd8", model_frame(6'd8, 32'h1AA), 48'h48000001AA87);
        chk("model_cmd17", model_frame(6'd17, 32'd0), 48'h510000000055);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_pins", {cs_n, sclk, mosi, cmd_ready, busy, resp_valid}, 6'b101100);
        chk("reset_resp", {resp_timeout, resp_r1}, 9'h0FF);
        rst_n = 1'b1;

        set_card(1, 8'h01, 8'hFF, 8'hFF);
        run_cmd(6'd0, 32'd0, lat);
        chk("cmd0_bytes", cap, 48'h400000000095);
        chk("cmd0_r1", resp_r1, 8'h01);
        chk("cmd0_timeout", resp_timeout, 1'b0);
        chk("cmd0_latency", 64'(lat), 64'(1 + 96 * D + 16 * D));

        run_cmd(6'd8, 32'h000001AA, lat);
        chk("cmd8_bytes", cap, 48'h48000001AA87);

        run_cmd(6'd17, 32'd0, lat);
        chk("cmd17_bytes", cap, 48'h510000000055);

        set_card(0, 8'hFF, 8'hFF, 8'hFF);
        run_cmd(6'd13, 32'h12345678, lat);
        chk("timeout_r1", resp_r1, 8'hFF);
        chk("timeout_flag", resp_timeout, 1'b1);
        chk("timeout_rises", 64'(rise_cnt), 64'd112);

        set_card(3, 8'hFF, 8'hFF, 8'h05);
        run_cmd(6'd55, 32'hDEADBEEF, lat);
        chk("third_r1", resp_r1, 8'h05);
        chk("third_timeout", resp_timeout, 1'b0);
        chk("third_latency", 64'(lat), 64'(1 + 144 * D));

        // cmd_valid held high with inputs churning during the transaction
        set_card(1, 8'h01, 8'hFF, 8'hFF);
        wait_ready();
        cmd_index = 6'd0;
        cmd_arg = 32'd0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!resp_valid && n < 3000) begin
            cmd_index = 6'($urandom);
            cmd_arg = $urandom;
            @(posedge clk); #1;
            n++;
        end
        if (!resp_valid) bound_fail("hold_resp_wait");
        chk("hold_first_bytes", cap, 48'h400000000095);
        cmd_index = 6'd17;
        cmd_arg = 32'd0;
        @(posedge clk); #1;
        chk("b2b_ready", cmd_ready, 1'b1);
        @(posedge clk); #1;
        chk("b2b_cs", cs_n, 1'b0);
        cmd_valid = 1'b0;
        t_acc = cyc;
        wait_resp(t_acc, lat);
        chk("b2b_bytes", cap, 48'h510000000055);
        chk("b2b_r1", resp_r1, 8'h01);

        // reset while bit 20 is on the wire
        wait_ready();
        cmd_index = 6'd8;
        cmd_arg = 32'h1AA;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (rise_cnt < 21 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (rise_cnt < 21) bound_fail("bit20_wait");
        rst_n = 1'b0;
        #1;
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_cs", cs_n, 1'b1);
        chk("rst_mosi_ready", {mosi, cmd_ready, busy}, 3'b110);
        chk("rst_r1", resp_r1, 8'hFF);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_cmd(6'd0, 32'd0, lat);
        chk("post_rst_bytes", cap, 48'h400000000095);
        chk("post_rst_r1", resp_r1, 8'h01);
        chk("post_rst_rises", 64'(rise_cnt), 64'd56);

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sd_cmd_master.md
# sd_cmd_master

SPI-mode SD command issuer for the controller side of the SD card link. Accepts a command index and 32-bit argument, builds the 6-byte SD command frame with CRC7, and shifts it out MSB-first over SPI mode 0. It then polls the card with 0xFF bytes until an R1 response byte (bit 7 = 0) arrives or a poll limit expires. It drives the `mosi`/`sclk`/`cs_n` lines that feed `sd_card_dummy` in simulation and the physical card in hardware.

## Interface
Parameters:
- `CLK_DIV`, 4: `clk` cycles per `sclk` half-period, ≥1.
- `MAX_POLL`, 8: maximum response-poll bytes before timeout, ≥1.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; **one clock (`clk`); asynchronous, active-low reset `rst_n`**.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  block idle, can accept a command.
- `cmd_index`  in  6  SD command index (CMD0 = 0).
- `cmd_arg`  in  32  command argument.
- `resp_valid`  out  1  one-cycle pulse: response fields valid.
- `resp_r1`  out  8  R1 byte received; 0xFF on timeout.
- `resp_timeout`  out  1  set with `resp_valid` when no R1 was received within `MAX_POLL` bytes.
- `busy`  out  1  transaction in progress (= !`cmd_ready`).
- `sclk`  out  1  SPI clock, idles low.
- `mosi`  out  1  SPI data to the card.
- `miso`  in  1  SPI data from the card.
- `cs_n`  out  1  chip select, active low.

## Operation
- Frame: byte0 = {2'b01, `cmd_index`}; bytes1–4 = `cmd_arg[31:0]`, MSB first; byte5 = {crc7, 1'b1}.
- CRC7: polynomial x^7+x^3+1, init 0, computed over the first 40 frame bits MSB-first. CRC is computed from the captured index and argument, before or during transmission.
- `cmd_index` and `cmd_arg` are captured on the accepting edge. Later input changes have no effect.
- States:
  - IDLE: `cmd_ready`=1. On `cmd_valid`&&`cmd_ready`, go to SEND.
  - SEND: shift 48 frame bits. After the 48th bit's falling edge, go to POLL.
  - POLL: `mosi`=1. Shift 8 bits of `miso` into the poll byte, MSB first.
    - After each byte, if byte[7]==0: store it in `resp_r1` and go to DONE.
    - Otherwise, if byte count == `MAX_POLL`: `resp_r1`=0xFF, `resp_timeout`=1, go to DONE.
    - Otherwise, poll the next byte.
  - DONE: `cs_n`=1, `resp_valid`=1 for one cycle, go to IDLE.
- `cmd_valid` while busy is ignored. No queuing.
- Reset, including mid-frame, immediately forces: IDLE, `sclk`=0, `cs_n`=1, `mosi`=1, `cmd_ready`=1, `busy`=0, `resp_valid`=0, `resp_timeout`=0, `resp_r1`=0xFF. No partial frame resumes after reset.

## Timing
- Cycle after acceptance: `cs_n`=0, `mosi`=frame bit 47, `sclk`=0, `cmd_ready`=0.
- `sclk` toggles every `CLK_DIV` `clk` cycles, giving one bit per 2·`CLK_DIV` cycles. The first rising edge comes `CLK_DIV` cycles after `cs_n` falls.
- `miso` is sampled on the `clk` edge that drives `sclk` high. `mosi` advances on the edge that drives `sclk` low, so it is stable across each rising edge.
- SEND lasts 48·2·`CLK_DIV` cycles. Each poll byte lasts 16·`CLK_DIV` cycles.
- DONE is entered on the cycle after the final falling edge of the deciding poll byte. `cs_n` rises and `resp_valid` pulses in that same cycle.
- `cmd_ready` returns to 1 on the next cycle. A new command is accepted back-to-back at that point.
- `resp_r1` and `resp_timeout` hold their values until the next `resp_valid`.
- Total latency, acceptance to `resp_valid`, with a response in poll byte k: 1 + 96·`CLK_DIV` + 16·`CLK_DIV`·k cycles.
- Rising-edge counts per transaction: exactly 48 + 8·k. With `cs_n` high, `sclk` is low and `mosi` is high.

## Test plan
- CMD0, arg 0, looped to `sd_card_dummy`: bytes on `mosi` are 40 00 00 00 00 95. `resp_r1`=0x01 with `resp_timeout`=0, from poll byte 1.
- CMD8, arg 0x000001AA: frame is 48 00 00 01 AA 87. CMD17, arg 0: frame is 51 00 00 00 00 55.
- `miso` stuck at 1, `MAX_POLL`=8: `resp_valid` with `resp_r1`=0xFF and `resp_timeout`=1 after exactly 112 rising edges of `sclk`.
- Model returns FF, FF, 05: `resp_r1`=0x05 after poll byte 3. Latency is 1 + 144·`CLK_DIV` cycles.
- `cmd_valid` held high with changing args during a transaction: only the captured command is sent. The next command starts the cycle after `resp_valid`.
- `rst_n` low mid-SEND (bit 20): `cs_n`=1 and `sclk`=0 immediately. After release, a new CMD0 produces a clean frame and response.
